// File: rtl/pkt_sram_pkg.sv
// Shared bus widths, constants and arbiter state type for pkt_sram and its
// neighbours (executor, cksum).
package pkt_sram_pkg;

    localparam int unsigned ADDR_BUS_W      = 32;
    localparam int unsigned DATA_BUS_W      = 32;
    localparam int unsigned MEM_WIDTH_BUS_W = 4;
    localparam int unsigned MEM_MAX_WIDTH   = 4;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;
    localparam logic [DATA_BUS_W-1:0] ZERO_WORD = '0;

    typedef enum logic {
        ARB_IDLE,
        ARB_HOST
    } arb_state_t;

    // Position within the access (0 = most significant byte) of the byte that lives in 'lane'.
    function automatic logic [1:0] lane_offset(input logic [1:0] lane, input logic [1:0] base);
        return lane - base;
    endfunction

endpackage

// File: rtl/pkt_sram_byte_bank.sv
// One 8-bit byte lane of pkt_sram: synchronous write, registered read.
module sram_byte_bank #(
    parameter int unsigned ROWS = 512
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [$clog2(ROWS)-1:0] addr,
    input  logic [7:0]              wdata,
    output logic [7:0]              rdata
);

    logic [7:0] mem [ROWS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/pkt_sram.sv
// Byte-addressed big-endian packet memory: executor port (1-4 bytes, unaligned) with
// fixed priority over a 32-bit host port. Optional SRAM_ERR_EN adds range/width errors.
module pkt_sram
    import pkt_sram_pkg::*;
#(
    parameter int unsigned DEPTH_BYTES = 2048
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mem_ce_i,
    input  logic                       mem_we_i,
    input  logic [ADDR_BUS_W-1:0]      mem_addr_i,
    input  logic [MEM_WIDTH_BUS_W-1:0] mem_width_i,
    input  logic [DATA_BUS_W-1:0]      mem_data_i,
    output logic [DATA_BUS_W-1:0]      mem_data_o,
    input  logic                       host_req_i,
    input  logic                       host_we_i,
    input  logic [ADDR_BUS_W-1:0]      host_addr_i,
    input  logic [DATA_BUS_W-1:0]      host_wdata_i,
    output logic                       host_ack_o,
    output logic                       host_rvalid_o,
    output logic [DATA_BUS_W-1:0]      host_rdata_o,
    output logic                       err_o
);

    localparam int unsigned ROWS = DEPTH_BYTES / 4;
    localparam int unsigned AW   = $clog2(DEPTH_BYTES);
    localparam int unsigned RW   = AW - 2;
`ifdef SRAM_ERR_EN
    localparam int unsigned BAW  = ADDR_BUS_W + 1;
`else
    localparam int unsigned BAW  = AW;
`endif

    arb_state_t state, state_next;

    logic            exec_active, host_grant, acc_en, acc_we, oor;
    logic [ADDR_BUS_W-1:0] acc_addr;
    logic [DATA_BUS_W-1:0] acc_data;
    logic [2:0]      acc_w;

    logic [3:0]      lane_act, lane_we;
    logic [1:0]      lane_off  [4];
    logic [BAW-1:0]  lane_addr [4];
    logic [RW-1:0]   lane_row  [4];
    logic [7:0]      lane_wdata[4];
    logic [7:0]      bank_q    [4];

    logic            exec_rd_q, host_rd_q, rd_zero;
    logic [1:0]      rd_a0;
    logic [2:0]      rd_w;
    logic [DATA_BUS_W-1:0] rd_word, mem_held, host_held;

    assign exec_active = mem_ce_i && (mem_width_i != '0) && (mem_width_i <= MEM_MAX_WIDTH);
    assign acc_en      = !rst && (exec_active || host_req_i);
    assign acc_we      = exec_active ? mem_we_i : host_we_i;
    assign acc_addr    = exec_active ? mem_addr_i : host_addr_i;
    assign acc_data    = exec_active ? mem_data_i : host_wdata_i;
    assign acc_w       = exec_active ? mem_width_i[2:0] : 3'(MEM_MAX_WIDTH);

    always_comb begin
        state_next = ARB_IDLE;
        host_grant = FALSE;
        host_ack_o = FALSE;
        if (!rst && host_req_i && !exec_active) begin
            state_next = ARB_HOST;
            host_grant = TRUE;
            host_ack_o = TRUE;
        end
    end

    // Each lane works out which byte of the access it holds, so a row-spanning access
    // simply puts its low lanes one row further on.
    always_comb begin
        oor = FALSE;
        for (int unsigned l = 0; l < 4; l++) begin
            lane_off[l]   = lane_offset(2'(l), acc_addr[1:0]);
            lane_addr[l]  = BAW'(acc_addr) + BAW'(lane_off[l]);
            lane_row[l]   = lane_addr[l][AW-1:2];
            lane_act[l]   = {1'b0, lane_off[l]} < acc_w;
            lane_wdata[l] = '0;
            if (lane_act[l]) begin
                lane_wdata[l] = 8'(acc_data >> (8 * (32'(acc_w) - 32'd1 - 32'(lane_off[l]))));
            end
`ifdef SRAM_ERR_EN
            if (lane_act[l] && (lane_addr[l][BAW-1:AW] != '0)) begin
                oor = TRUE;
            end
`endif
        end
    end

    always_comb begin
        for (int unsigned l = 0; l < 4; l++) begin
            lane_we[l] = acc_en && acc_we && lane_act[l] && !oor;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_lane
        sram_byte_bank #(.ROWS(ROWS)) u_bank (
            .clk   (clk),
            .we    (lane_we[g]),
            .addr  (lane_row[g]),
            .wdata (lane_wdata[g]),
            .rdata (bank_q[g])
        );
    end

    always_comb begin
        rd_word = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (i < 32'(rd_w)) begin
                rd_word = rd_word
                        | (32'(bank_q[2'(32'(rd_a0) + i)]) << (8 * (32'(rd_w) - 32'd1 - i)));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ARB_IDLE;
            exec_rd_q <= FALSE;
            host_rd_q <= FALSE;
            rd_zero   <= FALSE;
            rd_a0     <= '0;
            rd_w      <= '0;
            mem_held  <= ZERO_WORD;
            host_held <= ZERO_WORD;
        end else begin
            state     <= state_next;
            exec_rd_q <= exec_active && !mem_we_i;
            host_rd_q <= !host_we_i;
            rd_zero   <= oor;
            rd_a0     <= acc_addr[1:0];
            rd_w      <= acc_w;
            mem_held  <= mem_data_o;
            host_held <= host_rdata_o;
        end
    end

    // Read results come straight from the banks for one cycle, then from the hold registers.
    assign host_rvalid_o = (state == ARB_HOST) && host_rd_q;
    assign mem_data_o    = exec_rd_q     ? (rd_zero ? ZERO_WORD : rd_word) : mem_held;
    assign host_rdata_o  = host_rvalid_o ? (rd_zero ? ZERO_WORD : rd_word) : host_held;

`ifdef SRAM_ERR_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= FALSE;
        end else if ((mem_ce_i && (mem_width_i > MEM_MAX_WIDTH)) || (acc_en && oor)) begin
            err_q <= TRUE;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = FALSE;
`endif

endmodule

// File: tb/tb_pkt_sram.sv
// Self-checking bench for pkt_sram: byte-array reference model checked every cycle
// plus directed vectors with hand-computed literals.
module tb_pkt_sram;

    localparam int unsigned DEPTH = 2048;

    logic        clk = 0;
    logic        rst = 1;
    logic        mem_ce = 0, mem_we = 0;
    logic [31:0] mem_addr = 0, mem_wdata = 0;
    logic [3:0]  mem_width = 0;
    logic        host_req = 0, host_we = 0;
    logic [31:0] host_addr = 0, host_wdata = 0;
    logic [31:0] mem_data_o, host_rdata_o;
    logic        host_ack_o, host_rvalid_o, err_o;

    pkt_sram #(.DEPTH_BYTES(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_ce_i      (mem_ce),
        .mem_we_i      (mem_we),
        .mem_addr_i    (mem_addr),
        .mem_width_i   (mem_width),
        .mem_data_i    (mem_wdata),
        .mem_data_o    (mem_data_o),
        .host_req_i    (host_req),
        .host_we_i     (host_we),
        .host_addr_i   (host_addr),
        .host_wdata_i  (host_wdata),
        .host_ack_o    (host_ack_o),
        .host_rvalid_o (host_rvalid_o),
        .host_rdata_o  (host_rdata_o),
        .err_o         (err_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit checking = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain byte array, big-endian assembly.
    logic [7:0]  mm [DEPTH];
    logic [31:0] exp_mdata = 0, exp_hrdata = 0;
    logic        exp_rvalid = 0, exp_err = 0;

    task automatic model_access(input logic we, input logic [31:0] a, input int w,
                                input logic [31:0] d, output logic [31:0] rd);
        bit bad;
        int unsigned ba;
        bad = 0;
        rd  = 0;
`ifdef SRAM_ERR_EN
        bad = (64'(a) + 64'(w)) > 64'(DEPTH);
        if (bad) exp_err = 1;
`endif
        for (int i = 0; i < w; i++) begin
            ba = (a + 32'(i)) % DEPTH;
            if (we) begin
                if (!bad) mm[ba] = 8'(d >> (8 * (w - 1 - i)));
            end else begin
                rd = (rd << 8) | (bad ? 32'd0 : 32'(mm[ba]));
            end
        end
    endtask

    function automatic logic exec_on();
        return mem_ce && (mem_width >= 4'd1) && (mem_width <= 4'd4);
    endfunction

    always @(posedge clk) begin : model
        logic [31:0] rd;
        if (rst) begin
            exp_mdata  = 0;
            exp_hrdata = 0;
            exp_rvalid = 0;
            exp_err    = 0;
        end else begin
            exp_rvalid = 0;
`ifdef SRAM_ERR_EN
            if (mem_ce && mem_width > 4'd4) exp_err = 1;
`endif
            if (exec_on()) begin
                model_access(mem_we, mem_addr, int'(mem_width), mem_wdata, rd);
                if (!mem_we) exp_mdata = rd;
            end else if (host_req) begin
                model_access(host_we, host_addr, 4, host_wdata, rd);
                if (!host_we) begin
                    exp_hrdata = rd;
                    exp_rvalid = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            check("cyc_mem_data", mem_data_o, exp_mdata);
            check("cyc_host_rdata", host_rdata_o, exp_hrdata);
            check("cyc_rvalid", 32'(host_rvalid_o), 32'(exp_rvalid));
            check("cyc_ack", 32'(host_ack_o), 32'(!rst && host_req && !exec_on()));
            check("cyc_err", 32'(err_o), 32'(exp_err));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic exec(input logic we, input logic [31:0] a, input logic [3:0] w,
                        input logic [31:0] d);
        mem_ce = 1; mem_we = we; mem_addr = a; mem_width = w; mem_wdata = d;
        cyc();
        mem_ce = 0; mem_we = 0; mem_width = 0;
    endtask

    task automatic host(input logic we, input logic [31:0] a, input logic [31:0] d);
        bit acked;
        acked = 0;
        host_req = 1; host_we = we; host_addr = a; host_wdata = d;
        for (int k = 0; k < 20; k++) begin
            #1;
            acked = host_ack_o;
            cyc();
            if (acked) break;
        end
        host_req = 0; host_we = 0;
        if (!acked) check("host_ack_timeout", 32'(acked), 32'd1);
    endtask

    initial begin
        logic [7:0] b;
        int acks;

        repeat (2) cyc();
        checking = 1;
        check("rst_mem_data", mem_data_o, 32'h0);
        check("rst_host_rdata", host_rdata_o, 32'h0);
        check("rst_ack", 32'(host_ack_o), 32'h0);
        check("rst_rvalid", 32'(host_rvalid_o), 32'h0);
        check("rst_err", 32'(err_o), 32'h0);
        rst = 0;

        for (int r = 0; r < int'(DEPTH / 4); r++) begin
            b = 8'(r);
            host(1, 32'(4 * r), {b, b ^ 8'h11, b ^ 8'h22, b ^ 8'h33});
        end
        host(0, 32'h50, 32'h0);
        check("preload_rvalid", 32'(host_rvalid_o), 32'h1);
        check("preload_rdata", host_rdata_o, 32'h14053627);

        exec(1, 32'h10, 4'd4, 32'hDEADBEEF);
        exec(0, 32'h10, 4'd1, 32'h0);
        check("rd_w1_0x10", mem_data_o, 32'h000000DE);
        exec(0, 32'h13, 4'd1, 32'h0);
        check("rd_w1_0x13", mem_data_o, 32'h000000EF);

        exec(1, 32'h0E, 4'd4, 32'h11223344);
        exec(0, 32'h0F, 4'd2, 32'h0);
        check("rd_w2_0x0f", mem_data_o, 32'h00002233);
        exec(0, 32'h0E, 4'd4, 32'h0);
        check("rd_w4_0x0e", mem_data_o, 32'h11223344);

        exec(1, 32'h20, 4'd4, 32'h01020304);
        exec(1, 32'h24, 4'd4, 32'h05060708);
        exec(1, 32'h28, 4'd4, 32'h090A0B0C);

        // Host write held while the executor streams three reads.
        host_req = 1; host_we = 1; host_addr = 32'h40; host_wdata = 32'hCAFEF00D;
        acks = 0;
        for (int k = 0; k < 3; k++) begin
            mem_ce = 1; mem_we = 0; mem_addr = 32'h20 + 32'(4 * k); mem_width = 4'd4;
            #1;
            if (host_ack_o) acks++;
            cyc();
            case (k)
                0: check("stream_0x20", mem_data_o, 32'h01020304);
                1: check("stream_0x24", mem_data_o, 32'h05060708);
                default: check("stream_0x28", mem_data_o, 32'h090A0B0C);
            endcase
        end
        mem_ce = 0; mem_width = 0;
        #1;
        if (host_ack_o) acks++;
        check("host_ack_idle", 32'(host_ack_o), 32'h1);
        cyc();
        host_req = 0; host_we = 0;
        check("host_ack_count", 32'(acks), 32'd1);

        host_req = 1; host_we = 0; host_addr = 32'h40;
        #1;
        check("host_rd_ack", 32'(host_ack_o), 32'h1);
        cyc();
        host_req = 0;
        check("host_rd_rvalid", 32'(host_rvalid_o), 32'h1);
        check("host_rd_data", host_rdata_o, 32'hCAFEF00D);
        cyc();
        check("host_rvalid_drop", 32'(host_rvalid_o), 32'h0);
        check("host_rdata_hold", host_rdata_o, 32'hCAFEF00D);
        check("mem_data_hold", mem_data_o, 32'h090A0B0C);

        exec(0, 32'h10, 4'd0, 32'h0);
        check("width0_hold", mem_data_o, 32'h090A0B0C);
        exec(1, 32'h10, 4'd5, 32'hFFFFFFFF);
        exec(0, 32'h10, 4'd4, 32'h0);
        check("width5_nowrite", mem_data_o, 32'h3344BEEF);
`ifdef SRAM_ERR_EN
        check("width5_err", 32'(err_o), 32'h1);
        rst = 1; cyc(); rst = 0;
        check("err_cleared", 32'(err_o), 32'h0);

        exec(1, DEPTH - 2, 4'd4, 32'hA1B2C3D4);
        check("oor_err", 32'(err_o), 32'h1);
        exec(0, DEPTH - 2, 4'd4, 32'h0);
        check("oor_rd_zero", mem_data_o, 32'h0);
        exec(0, 32'h0, 4'd2, 32'h0);
        check("oor_nowrap", mem_data_o, 32'h00000011);
        repeat (3) cyc();
        check("err_sticky", 32'(err_o), 32'h1);
        rst = 1; cyc(); rst = 0;
        check("err_rst", 32'(err_o), 32'h0);
`else
        exec(1, DEPTH - 2, 4'd4, 32'hA1B2C3D4);
        exec(0, 32'h0, 4'd2, 32'h0);
        check("wrap_low", mem_data_o, 32'h0000C3D4);
        exec(0, DEPTH - 2, 4'd2, 32'h0);
        check("wrap_high", mem_data_o, 32'h0000A1B2);
        exec(0, DEPTH - 1, 4'd3, 32'h0);
        check("wrap_span", mem_data_o, 32'h00B2C3D4);
        check("err_tied", 32'(err_o), 32'h0);
`endif

        // Executor write coincident with reset must be dropped.
        mem_ce = 1; mem_we = 1; mem_addr = 32'h50; mem_width = 4'd4; mem_wdata = 32'h12345678;
        rst = 1;
        cyc();
        rst = 0; mem_ce = 0; mem_we = 0; mem_width = 0;
        check("rstw_mem_data", mem_data_o, 32'h0);
        check("rstw_host_rdata", host_rdata_o, 32'h0);
        check("rstw_ack", 32'(host_ack_o), 32'h0);
        check("rstw_rvalid", 32'(host_rvalid_o), 32'h0);
        check("rstw_err", 32'(err_o), 32'h0);
        exec(0, 32'h50, 4'd4, 32'h0);
        check("rstw_unchanged", mem_data_o, 32'h14053627);

        // Host read pending across reset is served once reset drops.
        host_req = 1; host_we = 0; host_addr = 32'h54;
        rst = 1;
        #1;
        check("rsth_no_ack", 32'(host_ack_o), 32'h0);
        cyc();
        rst = 0;
        #1;
        check("rsth_ack_after", 32'(host_ack_o), 32'h1);
        cyc();
        host_req = 0;
        check("rsth_rdata", host_rdata_o, 32'h15043726);

        repeat (2) cyc();
        checking = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pkt_sram.md
# pkt_sram

Byte-addressed packet/instruction memory that acts as the responder to the executor's SRAM interface (ce/we/addr/width/data). It serves variable-width (1–4 byte), possibly unaligned, big-endian reads and writes with one-cycle read latency. It also arbitrates a secondary 32-bit host port, used by packet ingress/egress to load and dump packet bytes and instruction lists, into the cycles the executor leaves idle.

## Interface
- DEPTH_BYTES, 2048 — memory size in bytes; must be a multiple of 4 and a power of two.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- mem_ce_i  in  1  executor access enable.
- mem_we_i  in  1  executor write (1) / read (0).
- mem_addr_i  in  `ADDR_BUS  executor byte address.
- mem_width_i  in  4  access width in bytes; 0 = no access.
- mem_data_i  in  `DATA_BUS  executor write data, right-justified.
- mem_data_o  out  `DATA_BUS  executor read data, right-justified, zero-extended.
- host_req_i  in  1  host access request; held high until acked.
- host_we_i  in  1  host write / read.
- host_addr_i  in  `ADDR_BUS  host byte address; always 4-byte access.
- host_wdata_i  in  `DATA_BUS  host write data.
- host_ack_o  out  1  one-cycle pulse: host access performed this cycle.
- host_rvalid_o  out  1  one-cycle pulse: host_rdata_o valid.
- host_rdata_o  out  `DATA_BUS  host read data.
- err_o  out  1  sticky range/width error (only with SRAM_ERR_EN).

## Operation
- Storage is 4 byte lanes. Byte at address a lives in lane a[1:0], row a>>2.
- An access of width w at address A touches bytes A..A+w-1. Each byte independently selects lane (A+i)%4 and row (A+i)>>2, so unaligned accesses spanning rows complete in one cycle.
- Byte order is big-endian:
  - Byte A is the most significant of the w-byte value.
  - Read: mem_data_o[8w-1:0] = {M[A],…,M[A+w-1]}, upper bits 0.
  - Write: M[A+i] = mem_data_i[8(w-1-i)+7 : 8(w-1-i)].
- Executor access is active when mem_ce_i=1 and 1≤mem_width_i≤4.
  - mem_width_i 0: no access.
  - mem_width_i 5–15: no access; sets err_o when SRAM_ERR_EN is defined.
- Arbitration is fixed priority:
  - An active executor access always wins and is never stalled; the executor has no stall input.
  - The host is served in any cycle with host_req_i=1 and no active executor access.
  - host_ack_o pulses in the serving cycle.
  - The host must drop or change host_req_i after an ack. A host that keeps host_req_i high receives another access the next free cycle.
- Arbiter states: IDLE (no host grant) and HOST (host granted this cycle), recomputed every cycle. No multi-cycle ownership.
- Address wrap without SRAM_ERR_EN: every byte address is taken modulo DEPTH_BYTES, so an access straddling the top wraps to byte 0.
- Memory contents are not cleared by reset.

## Timing
- Reset values: mem_data_o=0, host_rdata_o=0, host_ack_o=0, host_rvalid_o=0, err_o=0, arbiter IDLE.
- Executor read:
  - Address, width and ce are sampled at edge N.
  - mem_data_o holds the result from edge N through edge N+1.
  - mem_data_o keeps its last value until the next executor read.
  - Back-to-back reads with an incrementing address give a new word every cycle.
- Writes commit at the sampling edge. A read issued the next cycle to the same byte returns the new value.
- Host:
  - Ack is sampled at edge N.
  - host_rvalid_o=1 and host_rdata_o are valid from edge N to N+1 for reads only.
  - host_rdata_o holds between reads.
- rst asserted mid-access: the access in that cycle is dropped (no write). Outputs go to their reset values at that edge. A pending host request is re-arbitrated after reset deasserts.

## Configuration
- SRAM_ERR_EN defined:
  - Any access with a byte outside 0..DEPTH_BYTES-1, or an executor width of 5–15, performs no write.
  - Such a read returns 0.
  - err_o is set and stays set until rst.
  - Host out-of-range requests are still acked.
- SRAM_ERR_EN undefined: err_o is tied 0, addresses wrap modulo DEPTH_BYTES, and widths of 5–15 are ignored.

## Structure
- def.v holds `ADDR_BUS, `DATA_BUS, `TRUE/`FALSE and `ZERO_WORD.
- Add to def.v: `MEM_WIDTH_BUS (3:0) and `MEM_MAX_WIDTH (4), shared with executor and cksum.
- Sub-module sram_byte_bank: one synchronous-write, synchronous-read 8-bit bank of DEPTH_BYTES/4 rows, instantiated ×4. Lane address/rotate logic stays in pkt_sram.

## Test plan
- Aligned width-4 write at addr 0x10 with data 0xDEADBEEF, then a width-1 read at 0x10 → mem_data_o=0x000000DE one cycle later; a width-1 read at 0x13 → 0x000000EF.
- Unaligned width-4 write at 0x0E with 0x11223344, then a width-2 read at 0x0F → 0x00002233; a width-4 read at 0x0E → 0x11223344 (row-spanning).
- Executor streaming reads at 0x20, 0x24, 0x28 on consecutive cycles → three words, each returned one cycle after its address, with no gaps.
- Host write req held while the executor is active for 3 cycles → host_ack_o pulses in the first executor-idle cycle only; a host read → host_rvalid_o the next cycle with the correct data.
- Width-4 access at DEPTH_BYTES-2:
  - Without SRAM_ERR_EN, the write wraps bytes into 0 and 1.
  - With SRAM_ERR_EN, there is no write, the read returns 0 and err_o stays 1 until rst.
- rst pulsed during a pending executor write → memory unchanged at that address; all outputs are 0 the cycle after.
